// File: rtl/bp_check_ctrl.sv
// Branch-prediction check and recovery controller: in-order tracking queue of
// predicted branches, resolve-time compare, predictor training and mispredict recovery.
module bp_check_ctrl #(
    parameter int DEPTH        = 4,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       fs_push_valid,
    output logic                       fs_push_ready,
    input  logic [31:0]                fs_push_pc,
    input  logic                       fs_push_taken,
    input  logic [31:0]                fs_push_target,
    input  logic                       es_res_valid,
    input  logic [31:0]                es_res_pc,
    input  logic                       es_res_taken,
    input  logic [31:0]                es_res_target,
    output logic                       bp_we,
    output logic                       bp_in_b,
    output logic                       redirect_valid,
    output logic [31:0]                redirect_pc,
    output logic                       flush,
    output logic [$clog2(DEPTH+1)-1:0] q_count,
    output logic                       err
);

    // State table:
    //   ST_RUN   | normal operation, pushes accepted, resolves checked
    //   ST_FLUSH | recovery window after a mispredict/error, pushes and resolves ignored
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int FW = $clog2(FLUSH_CYCLES + 1);

    typedef enum logic {ST_RUN, ST_FLUSH} state_t;

    state_t          state_q, state_d;
    logic [FW-1:0]   flush_cnt_q, flush_cnt_d;
    logic [AW-1:0]   rd_ptr_q, wr_ptr_q;
    logic [CW-1:0]   count_q, count_d;
    logic [31:0]     pc_mem_q     [DEPTH];
    logic [31:0]     target_mem_q [DEPTH];
    logic [DEPTH-1:0] taken_mem_q;

    logic        bp_we_d, bp_in_b_d, redirect_valid_d, flush_d, err_d;
    logic [31:0] redirect_pc_d;

    logic        res_run, q_empty, is_err, is_mis, recover, do_pop, do_push;
    logic [31:0] head_pc, head_target, next_pc;
    logic        head_taken;

    assign head_pc     = pc_mem_q[rd_ptr_q];
    assign head_target = target_mem_q[rd_ptr_q];
    assign head_taken  = taken_mem_q[rd_ptr_q];
    assign q_empty     = (count_q == '0);
    assign res_run     = es_res_valid && (state_q == ST_RUN);
    assign is_err      = res_run && (q_empty || (es_res_pc != head_pc));
    assign is_mis      = res_run && !is_err &&
                         ((head_taken != es_res_taken) ||
                          (head_taken && es_res_taken && (head_target != es_res_target)));
    assign recover     = is_err || is_mis;
    assign do_pop      = res_run && !recover;
    // Pushes arriving alongside a recovery are wrong-path and dropped.
    assign do_push     = fs_push_valid && fs_push_ready && !recover;
    assign next_pc     = es_res_taken ? es_res_target : (es_res_pc + 32'd4);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_RUN;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        case (state_q)
            ST_RUN: begin
                if (recover) begin
                    state_d     = ST_FLUSH;
                    flush_cnt_d = FW'(FLUSH_CYCLES - 1);
                end
            end
            ST_FLUSH: begin
                if (flush_cnt_q == '0) begin
                    state_d = ST_RUN;
                end else begin
                    flush_cnt_d = flush_cnt_q - 1'b1;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_comb begin
        fs_push_ready    = !reset && (state_q == ST_RUN) && (count_q < CW'(DEPTH));
        bp_we_d          = res_run && !is_err;
        bp_in_b_d        = bp_we_d && es_res_taken;
        redirect_valid_d = recover;
        flush_d          = recover;
        err_d            = is_err;
        redirect_pc_d    = recover ? next_pc : 32'd0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bp_we          <= 1'b0;
            bp_in_b        <= 1'b0;
            redirect_valid <= 1'b0;
            redirect_pc    <= 32'd0;
            flush          <= 1'b0;
            err            <= 1'b0;
        end else begin
            bp_we          <= bp_we_d;
            bp_in_b        <= bp_in_b_d;
            redirect_valid <= redirect_valid_d;
            redirect_pc    <= redirect_pc_d;
            flush          <= flush_d;
            err            <= err_d;
        end
    end

    always_comb begin
        count_d = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset || recover) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !reset) begin
            pc_mem_q[wr_ptr_q]     <= fs_push_pc;
            target_mem_q[wr_ptr_q] <= fs_push_target;
            taken_mem_q[wr_ptr_q]  <= fs_push_taken;
        end
    end

    assign q_count = count_q;

endmodule
